// File: rtl/flit_vc_receiver_pkg.sv
// Shared NoC definitions for the flit VC receiver.
// Flit layout: {hdr, tail, vc_onehot[V], payload[Fpay]}.
package flit_vc_receiver_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  localparam int PAY_LSB = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int flit_w(input int v, input int fpay);
    return 2 + v + fpay;
  endfunction

  function automatic int hdr_pos(input int v, input int fpay);
    return flit_w(v, fpay) - 1;
  endfunction

  function automatic int tail_pos(input int v, input int fpay);
    return flit_w(v, fpay) - 2;
  endfunction

  function automatic int vc_lsb(input int fpay);
    return fpay;
  endfunction

endpackage

// File: rtl/flit_vc_receiver_fifo.sv
// Per-VC flit buffer with occupancy counter.
// The head flit is captured into rd_data on the pop edge.
module vc_flit_fifo
  import flit_vc_receiver_pkg::*;
#(
  parameter int B = 4,
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         not_empty,
  output logic         full
);

  localparam int AW = clog2(B);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [B];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(B));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // B is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flit_vc_receiver.sv
// Input-port flit receiver: V virtual channels, per-VC packet
// FSM, credit return and sticky error reporting.
module flit_vc_receiver
  import flit_vc_receiver_pkg::*;
#(
  parameter int V    = 4,
  parameter int Fpay = 32,
  parameter int B    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [flit_w(V,Fpay)-1:0] flit_in,
  input  logic                      flit_in_we,
  input  logic [V-1:0]              rd_vc,
  output logic [flit_w(V,Fpay)-1:0] flit_out,
  output logic                      flit_out_valid,
  output logic [V-1:0]              vc_not_empty,
  output logic [V-1:0]              credit_out,
  output logic                      err_onehot,
  output logic                      err_overflow,
  output logic                      err_protocol,
  output logic                      err_underflow
);

  localparam int Fw   = flit_w(V, Fpay);
  localparam int HDR  = hdr_pos(V, Fpay);
  localparam int TAIL = tail_pos(V, Fpay);
  localparam int VCL  = vc_lsb(Fpay);

  logic [V-1:0]  wr_vc;
  logic [V-1:0]  push;
  logic [V-1:0]  pop;
  logic [V-1:0]  full;
  logic [V-1:0]  bad_seq;
  logic [V-1:0]  sel_q;
  logic [Fw-1:0] head [V];
  pkt_state_e    state_q [V];

  logic hdr, tail;
  logic wr_ok, rd_ok;
  logic oh_now, ovf_now, udf_now, proto_now;

  assign wr_vc = flit_in[VCL +: V];
  assign hdr   = flit_in[HDR];
  assign tail  = flit_in[TAIL];
  assign wr_ok = flit_in_we && $onehot(wr_vc);
  assign rd_ok = $onehot(rd_vc);

  // A full VC still accepts a write when it is popped this cycle.
  always_comb begin
    push    = '0;
    pop     = '0;
    bad_seq = '0;
    for (int v = 0; v < V; v++) begin
      pop[v]  = rd_ok && rd_vc[v] && vc_not_empty[v];
      push[v] = wr_ok && wr_vc[v] && (!full[v] || pop[v]);
      bad_seq[v] = (state_q[v] == IDLE) ? !hdr : hdr;
    end
  end

  assign oh_now    = (flit_in_we && !$onehot(wr_vc))
                   || (|rd_vc && !rd_ok);
  assign ovf_now   = wr_ok && |(wr_vc & full & ~pop);
  assign udf_now   = rd_ok && |(rd_vc & ~vc_not_empty);
  assign proto_now = |(push & bad_seq);

  for (genvar g = 0; g < V; g++) begin : g_vc
    vc_flit_fifo #(
      .B (B),
      .W (Fw)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .pop       (pop[g]),
      .wr_data   (flit_in),
      .rd_data   (head[g]),
      .not_empty (vc_not_empty[g]),
      .full      (full[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q         <= '0;
      err_onehot    <= 1'b0;
      err_overflow  <= 1'b0;
      err_protocol  <= 1'b0;
      err_underflow <= 1'b0;
      for (int v = 0; v < V; v++) state_q[v] <= IDLE;
    end else begin
      sel_q         <= pop;
      err_onehot    <= err_onehot    | oh_now;
      err_overflow  <= err_overflow  | ovf_now;
      err_protocol  <= err_protocol  | proto_now;
      err_underflow <= err_underflow | udf_now;
      // Illegal flits still steer the FSM as if they were legal.
      for (int v = 0; v < V; v++) begin
        if (push[v]) begin
          if (hdr)       state_q[v] <= tail ? IDLE : IN_PKT;
          else if (tail) state_q[v] <= IDLE;
        end
      end
    end
  end

  always_comb begin
    flit_out = '0;
    for (int v = 0; v < V; v++)
      if (sel_q[v]) flit_out = flit_out | head[v];
  end

  assign flit_out_valid = |sel_q;
  assign credit_out     = sel_q;

endmodule
